// File: rtl/control_puerta_pkg.sv
// rtl/control_puerta_pkg.sv - state codes and helpers shared by the door sequencer
//
// Purpose : state encoding for control_puerta (estado debug codes 0..4) and a
//           small constant helper used to size the shared timer.
// Ports   : none (package).
`timescale 1ns/1ps
package control_puerta_pkg;

    localparam int ST_W = 3;

    // Codes are visible on the estado debug port, so they are fixed explicitly.
    typedef enum logic [ST_W-1:0] {
        CERRADA  = 3'd0,
        ABRIENDO = 3'd1,
        ABIERTA  = 3'd2,
        CERRANDO = 3'd3,
        FALLA    = 3'd4
    } estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/control_puerta_temporizador.sv
// rtl/control_puerta_temporizador.sv - cycle counter with clear/enable and terminal compare
//
// Purpose : single timer shared by all timed states of the door sequencer.
//           The owner decides when to clear or advance it and supplies the
//           terminal value for the state it is in.
// Ports   : clk       in  1  rising-edge clock
//           reset     in  1  asynchronous active-low reset (count -> 0)
//           clr       in  1  synchronous clear, wins over en
//           en        in  1  advance the count by one
//           fin_valor in  W  terminal value to compare against
//           fin       out 1  count == fin_valor (combinational)
`timescale 1ns/1ps
module control_puerta_temporizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] fin_valor,
    output logic         fin
);

    logic [W-1:0] cuenta;

    // The owner never enables the count once fin is reached, so no wrap guard
    // is needed here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (clr) begin
            cuenta <= '0;
        end else if (en) begin
            cuenta <= cuenta + 1'b1;
        end
    end

    assign fin = (cuenta == fin_valor);

endmodule

// File: rtl/control_puerta.sv
// rtl/control_puerta.sv - motorised door sequencer (open on motion, timed hold, close, fault latch)
//
// Purpose : Moore FSM driving the open/close motor of one door. Opens on motion,
//           holds open for T_ESPERA idle cycles, closes, re-opens on motion while
//           closing, and latches a fault on travel timeout, contradictory limit
//           switches or more than MAX_REINTENTOS re-opens in one close attempt.
// Ports   : clk          in  1  rising-edge clock
//           reset        in  1  asynchronous active-low reset
//           sm           in  1  motion sensor, 1 = motion
//           sf_abierta   in  1  open limit switch, 1 = fully open
//           sf_cerrada   in  1  closed limit switch, 1 = fully closed
//           borrar       in  1  fault clear, only honoured in FALLA
//           motor_abrir  out 1  drive motor open
//           motor_cerrar out 1  drive motor closed
//           espera       out 1  door held open
//           falla        out 1  latched fault
//           estado       out 3  current state code
`timescale 1ns/1ps
module control_puerta
    import control_puerta_pkg::*;
#(
    parameter int T_ESPERA       = 8,
    parameter int T_MAX_MOV      = 16,
    parameter int MAX_REINTENTOS = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sm,
    input  logic            sf_abierta,
    input  logic            sf_cerrada,
    input  logic            borrar,
    output logic            motor_abrir,
    output logic            motor_cerrar,
    output logic            espera,
    output logic            falla,
    output logic [ST_W-1:0] estado
);

    localparam int TW = $clog2(max_int(T_ESPERA, T_MAX_MOV));
    localparam int RW = $clog2(MAX_REINTENTOS + 1);

    localparam logic [TW-1:0] FIN_ESPERA = TW'(T_ESPERA - 1);
    localparam logic [TW-1:0] FIN_MOV    = TW'(T_MAX_MOV - 1);
    localparam logic [RW-1:0] REIN_MAX   = RW'(MAX_REINTENTOS);

    estado_t       st, st_n;
    logic [RW-1:0] rein, rein_n;
    logic          tmr_clr, tmr_en, tmr_fin;
    logic [TW-1:0] tmr_cmp;
    logic          ambos_sf;

    // Both limit switches at once is physically impossible: treat as sensor fault.
    assign ambos_sf = sf_abierta & sf_cerrada;

    control_puerta_temporizador #(
        .W (TW)
    ) u_tmr (
        .clk       (clk),
        .reset     (reset),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .fin_valor (tmr_cmp),
        .fin       (tmr_fin)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st   <= CERRADA;
            rein <= '0;
        end else begin
            st   <= st_n;
            rein <= rein_n;
        end
    end

    always_comb begin
        st_n    = st;
        rein_n  = rein;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        tmr_cmp = FIN_MOV;
        case (st)
            CERRADA: begin
                if (sm) begin
                    st_n    = ABRIENDO;
                    tmr_clr = 1'b1;
                end
            end
            ABRIENDO: begin
                if (ambos_sf) begin
                    st_n = FALLA;
                end else if (sf_abierta) begin
                    st_n    = ABIERTA;
                    tmr_clr = 1'b1;
                end else if (tmr_fin) begin
                    st_n = FALLA;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ABIERTA: begin
                tmr_cmp = FIN_ESPERA;
                if (sm) begin
                    // Any motion restarts the full hold time.
                    tmr_clr = 1'b1;
                end else if (tmr_fin) begin
                    st_n    = CERRANDO;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            CERRANDO: begin
                // Motion is checked before sf_cerrada so a person caught at the
                // last moment still re-opens the door.
                if (ambos_sf) begin
                    st_n = FALLA;
                end else if (sm && (rein == REIN_MAX)) begin
                    st_n = FALLA;
                end else if (sm) begin
                    st_n    = ABRIENDO;
                    rein_n  = rein + 1'b1;
                    tmr_clr = 1'b1;
                end else if (sf_cerrada) begin
                    st_n   = CERRADA;
                    rein_n = '0;
                end else if (tmr_fin) begin
                    st_n = FALLA;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            FALLA: begin
                if (borrar) begin
                    st_n    = CERRADA;
                    rein_n  = '0;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                st_n = FALLA;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as estado; the decode is one-hot so the motors cannot both be on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            motor_abrir  <= 1'b0;
            motor_cerrar <= 1'b0;
            espera       <= 1'b0;
            falla        <= 1'b0;
        end else begin
            motor_abrir  <= (st_n == ABRIENDO);
            motor_cerrar <= (st_n == CERRANDO);
            espera       <= (st_n == ABIERTA);
            falla        <= (st_n == FALLA);
        end
    end

    assign estado = st;

endmodule

// File: tb/tb_control_puerta.sv
// tb/tb_control_puerta.sv - self-checking bench for control_puerta
`timescale 1ns/1ps
module tb_control_puerta;

    localparam int T_ESPERA       = 8;
    localparam int T_MAX_MOV      = 16;
    localparam int MAX_REINTENTOS = 3;

    logic       clk = 1'b0;
    logic       reset, sm, sf_abierta, sf_cerrada, borrar;
    logic       motor_abrir, motor_cerrar, espera, falla;
    logic [2:0] estado;
    logic [6:0] dut_v;

    int n_chk = 0;
    int n_fail = 0;

    control_puerta #(
        .T_ESPERA       (T_ESPERA),
        .T_MAX_MOV      (T_MAX_MOV),
        .MAX_REINTENTOS (MAX_REINTENTOS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sm           (sm),
        .sf_abierta   (sf_abierta),
        .sf_cerrada   (sf_cerrada),
        .borrar       (borrar),
        .motor_abrir  (motor_abrir),
        .motor_cerrar (motor_cerrar),
        .espera       (espera),
        .falla        (falla),
        .estado       (estado)
    );

    always #1 clk = ~clk;

    assign dut_v = {estado, motor_abrir, motor_cerrar, espera, falla};

    // Reference model: door position/phase as a spec code, time spent in the
    // current timed phase, and re-opens used in the current close attempt.
    int m_st = 0;
    int m_t = 0;
    int m_rein = 0;

    function automatic logic [6:0] m_exp();
        return {3'(m_st), m_st == 1, m_st == 3, m_st == 2, m_st == 4};
    endfunction

    task automatic model_step(input logic a, input logic fo, input logic fc, input logic b);
        int nx;
        nx = m_st;
        if (m_st == 0) begin
            if (a) begin nx = 1; m_t = 0; end
        end else if (m_st == 1) begin
            if (fo && fc) nx = 4;
            else if (fo) begin nx = 2; m_t = 0; end
            else if (m_t + 1 >= T_MAX_MOV) nx = 4;
            else m_t = m_t + 1;
        end else if (m_st == 2) begin
            if (a) m_t = 0;
            else if (m_t + 1 >= T_ESPERA) begin nx = 3; m_t = 0; end
            else m_t = m_t + 1;
        end else if (m_st == 3) begin
            if (fo && fc) nx = 4;
            else if (a && m_rein >= MAX_REINTENTOS) nx = 4;
            else if (a) begin nx = 1; m_rein = m_rein + 1; m_t = 0; end
            else if (fc) begin nx = 0; m_rein = 0; end
            else if (m_t + 1 >= T_MAX_MOV) nx = 4;
            else m_t = m_t + 1;
        end else begin
            if (b) begin nx = 0; m_t = 0; m_rein = 0; end
        end
        m_st = nx;
    endtask

    task automatic model_reset();
        m_st = 0; m_t = 0; m_rein = 0;
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (estado,ma,mc,esp,fal) at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, and check the DUT against the model.
    task automatic tick(input logic a, input logic fo, input logic fc, input logic b);
        sm = a; sf_abierta = fo; sf_cerrada = fc; borrar = b;
        @(posedge clk);
        model_step(a, fo, fc, b);
        #0.5;
        chk("model", dut_v, m_exp());
        chk("motor_excl", {6'd0, motor_abrir & motor_cerrar}, 7'd0);
    endtask

    typedef struct {
        logic       sm, fo, fc, b;
        int         reps;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[32];
    int   n_tbl = 0;

    task automatic add(input logic a, input logic fo, input logic fc, input logic b,
                       input int r, input logic [2:0] e, input logic [3:0] o);
        tbl[n_tbl].sm   = a;
        tbl[n_tbl].fo   = fo;
        tbl[n_tbl].fc   = fc;
        tbl[n_tbl].b    = b;
        tbl[n_tbl].reps = r;
        tbl[n_tbl].exp  = {e, o};
        n_tbl++;
    endtask

    initial begin
        // outputs nibble: {motor_abrir, motor_cerrar, espera, falla}
        // normal cycle
        add(1, 0, 0, 0, 1,  3'd1, 4'b1000);
        add(0, 0, 0, 0, 2,  3'd1, 4'b1000);
        add(0, 1, 0, 0, 1,  3'd2, 4'b0010);
        add(0, 0, 0, 0, 7,  3'd2, 4'b0010);
        add(0, 0, 0, 0, 1,  3'd3, 4'b0100);
        add(0, 0, 0, 0, 4,  3'd3, 4'b0100);
        add(0, 0, 1, 0, 1,  3'd0, 4'b0000);
        add(0, 0, 1, 0, 2,  3'd0, 4'b0000);
        // sm beats sf_cerrada in CERRANDO, then both switches in ABRIENDO
        add(1, 0, 0, 0, 1,  3'd1, 4'b1000);
        add(0, 1, 0, 0, 1,  3'd2, 4'b0010);
        add(0, 0, 0, 0, 7,  3'd2, 4'b0010);
        add(0, 0, 0, 0, 1,  3'd3, 4'b0100);
        add(1, 0, 1, 0, 1,  3'd1, 4'b1000);
        add(0, 1, 1, 0, 1,  3'd4, 4'b0001);
        add(0, 0, 0, 0, 2,  3'd4, 4'b0001);
        add(0, 0, 0, 1, 1,  3'd0, 4'b0000);
        add(0, 0, 0, 1, 1,  3'd0, 4'b0000);
        // opening timeout
        add(1, 0, 0, 0, 1,  3'd1, 4'b1000);
        add(0, 0, 0, 0, 15, 3'd1, 4'b1000);
        add(0, 0, 0, 0, 1,  3'd4, 4'b0001);
        add(0, 0, 0, 1, 1,  3'd0, 4'b0000);
        // hold extension: motion on the 5th open cycle
        add(1, 0, 0, 0, 1,  3'd1, 4'b1000);
        add(0, 1, 0, 0, 1,  3'd2, 4'b0010);
        add(0, 0, 0, 0, 4,  3'd2, 4'b0010);
        add(1, 0, 0, 0, 1,  3'd2, 4'b0010);
        add(0, 0, 0, 0, 7,  3'd2, 4'b0010);
        add(0, 0, 0, 0, 1,  3'd3, 4'b0100);
        add(0, 0, 1, 0, 1,  3'd0, 4'b0000);

        sm = 0; sf_abierta = 0; sf_cerrada = 0; borrar = 0;
        reset = 1'b1;
        #0.5 reset = 1'b0;
        #3.0 chk("reset_state", dut_v, 7'd0);
        #0.5 reset = 1'b1;

        for (int i = 0; i < n_tbl; i++) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                tick(tbl[i].sm, tbl[i].fo, tbl[i].fc, tbl[i].b);
                chk($sformatf("vec%0d_%0d", i, k), dut_v, tbl[i].exp);
            end
        end

        // re-opens while closing: three allowed, the fourth faults
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        repeat (T_ESPERA) tick(0, 0, 0, 0);
        chk("reopen_closing", dut_v, {3'd3, 4'b0100});
        for (int r = 0; r <= MAX_REINTENTOS; r++) begin
            tick(1, 0, 0, 0);
            if (r < MAX_REINTENTOS) begin
                chk($sformatf("reopen_%0d", r), dut_v, {3'd1, 4'b1000});
                tick(0, 1, 0, 0);
                repeat (T_ESPERA) tick(0, 0, 0, 0);
                chk($sformatf("reclose_%0d", r), dut_v, {3'd3, 4'b0100});
            end else begin
                chk("reopen_fault", dut_v, {3'd4, 4'b0001});
            end
        end
        tick(0, 0, 0, 1);
        chk("reopen_clear", dut_v, 7'd0);

        // asynchronous reset while opening
        tick(1, 0, 0, 0);
        chk("pre_async", dut_v, {3'd1, 4'b1000});
        reset = 1'b0;
        #0.2;
        chk("async_reset", dut_v, 7'd0);
        model_reset();
        #0.2 reset = 1'b1;
        tick(0, 0, 0, 0);
        chk("after_async", dut_v, 7'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
